mine_board_ctrl: RTL and testbench

Game controller for the 8x8 Minesweeper board. It latches a mine layout and precomputes the neighbour-mine count of every cell. It then moves a cursor from debounced button pulses and reveals or flags cells, and it decides win or lose. Its 64-bit `revealed`/`flagged` vectors use the same cell numbering as the VGA cell-position decoder (index = row*8 + col, row 0 at top, col 0 at left), so the renderer can AND them with the per-pixel cell-hit vector.

---
 rtl/mine_board_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mine_board_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mine_board_ctrl.sv
// 8x8 Minesweeper controller: latches a layout, scans neighbour counts (one cell/clk, 64 clks busy), then runs cursor/reveal/flag play.
// Button effects are visible one edge after the pulse; non-start pulses while busy, in IDLE, LOSE or WIN are dropped.
module mine_board_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] mine_map,
    input  logic        btn_start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_reveal,
    input  logic        btn_flag,
    input  logic [5:0]  rd_idx,
    output logic [3:0]  rd_count,
    output logic [5:0]  cursor,
    output logic [63:0] revealed,
    output logic [63:0] flagged,
    output logic [1:0]  state,
    output logic        busy,
    output logic [6:0]  mines
);

    // Low two bits are the reported state code; bit 2 marks LOAD (busy).
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_PLAY = 3'b001,
        S_LOSE = 3'b010,
        S_WIN  = 3'b011,
        S_LOAD = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] mine_q, mine_d;
    logic [63:0] revealed_q, revealed_d;
    logic [63:0] flagged_q, flagged_d;
    logic [5:0]  cursor_q, cursor_d;
    logic [6:0]  mines_q, mines_d;
    logic [6:0]  safe_q, safe_d;
    logic [5:0]  scan_q, scan_d;
    logic [3:0]  count_q [64];
    logic [63:0] cur_bit;
    logic [63:0] new_bits;

    // In-bounds neighbours of a cell; row and column are clamped separately so nothing wraps.
    function automatic logic [63:0] nbr_mask(input logic [5:0] idx);
        logic [63:0] m;
        int r, c, rr, cc;
        m = '0;
        r = int'(idx[5:3]);
        c = int'(idx[2:0]);
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                    m[6'(rr * 8 + cc)] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [3:0] nbr_count(input logic [63:0] m, input logic [5:0] idx);
        return 4'($countones(nbr_mask(idx) & m));
    endfunction

    always_comb begin
        state_d    = state_q;
        mine_d     = mine_q;
        revealed_d = revealed_q;
        flagged_d  = flagged_q;
        cursor_d   = cursor_q;
        mines_d    = mines_q;
        safe_d     = safe_q;
        scan_d     = scan_q;
        cur_bit    = '0;
        new_bits   = '0;
        if (btn_start) begin
            mine_d     = mine_map;
            revealed_d = '0;
            flagged_d  = '0;
            cursor_d   = '0;
            mines_d    = '0;
            safe_d     = '0;
            scan_d     = '0;
            state_d    = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    mines_d = mines_q + 7'(mine_q[scan_q]);
                    scan_d  = scan_q + 6'd1;
                    if (scan_q == 6'd63)
                        state_d = (mines_d == 7'd64) ? S_WIN : S_PLAY;
                end
                S_PLAY: begin
                    if (safe_q == 7'd64 - mines_q) begin
                        state_d = S_WIN;
                    end else if (btn_reveal) begin
                        if (!revealed_q[cursor_q] && !flagged_q[cursor_q]) begin
                            if (mine_q[cursor_q]) begin
                                revealed_d = revealed_q | mine_q;
                                state_d    = S_LOSE;
                            end else begin
                                cur_bit[cursor_q] = 1'b1;
                                new_bits = cur_bit;
                                // Single-level opening around a zero cell; no recursive flood.
                                if (count_q[cursor_q] == 4'd0)
                                    new_bits = new_bits | (nbr_mask(cursor_q) & ~mine_q & ~flagged_q);
                                new_bits   = new_bits & ~revealed_q;
                                revealed_d = revealed_q | new_bits;
                                safe_d     = safe_q + 7'($countones(new_bits));
                            end
                        end
                    end else if (btn_flag) begin
                        if (!revealed_q[cursor_q])
                            flagged_d[cursor_q] = ~flagged_q[cursor_q];
                    end else if (btn_up) begin
                        if (cursor_q[5:3] != 3'd0) cursor_d = cursor_q - 6'd8;
                    end else if (btn_down) begin
                        if (cursor_q[5:3] != 3'd7) cursor_d = cursor_q + 6'd8;
                    end else if (btn_left) begin
                        if (cursor_q[2:0] != 3'd0) cursor_d = cursor_q - 6'd1;
                    end else if (btn_right) begin
                        if (cursor_q[2:0] != 3'd7) cursor_d = cursor_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mine_q     <= '0;
            revealed_q <= '0;
            flagged_q  <= '0;
            cursor_q   <= '0;
            mines_q    <= '0;
            safe_q     <= '0;
            scan_q     <= '0;
        end else begin
            state_q    <= state_d;
            mine_q     <= mine_d;
            revealed_q <= revealed_d;
            flagged_q  <= flagged_d;
            cursor_q   <= cursor_d;
            mines_q    <= mines_d;
            safe_q     <= safe_d;
            scan_q     <= scan_d;
        end
    end

    // Counts are cleared on start so unscanned cells read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) count_q[i] <= '0;
        end else if (btn_start) begin
            for (int i = 0; i < 64; i++) count_q[i] <= '0;
        end else if (state_q == S_LOAD) begin
            count_q[scan_q] <= nbr_count(mine_q, scan_q);
        end
    end

    assign rd_count = count_q[rd_idx];
    assign cursor   = cursor_q;
    assign revealed = revealed_q;
    assign flagged  = flagged_q;
    assign state    = state_q[1:0];
    assign busy     = state_q[2];
    assign mines    = mines_q;

endmodule

// File: tb/tb_mine_board_ctrl.sv
// Directed bench for mine_board_ctrl: hand-computed expectations checked with immediate assertions.
module tb_mine_board_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] mine_map;
    logic        btn_start, btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;
    logic [5:0]  rd_idx;
    logic [3:0]  rd_count;
    logic [5:0]  cursor;
    logic [63:0] revealed, flagged;
    logic [1:0]  state;
    logic        busy;
    logic [6:0]  mines;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    localparam logic [5:0] B_UP = 6'b100000, B_DOWN = 6'b010000, B_LEFT = 6'b001000,
                           B_RIGHT = 6'b000100, B_REVEAL = 6'b000010, B_FLAG = 6'b000001;

    always #5 clk = ~clk;

    mine_board_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mine_map(mine_map), .btn_start(btn_start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_reveal(btn_reveal), .btn_flag(btn_flag), .rd_idx(rd_idx), .rd_count(rd_count),
        .cursor(cursor), .revealed(revealed), .flagged(flagged), .state(state),
        .busy(busy), .mines(mines)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [5:0] b);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = b;
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = '0;
    endtask

    task automatic press_n(input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    // Returns the number of sampled cycles with busy high (bounded).
    task automatic start_game(input logic [63:0] map, output int busy_cycles);
        @(negedge clk);
        mine_map  = map;
        btn_start = 1'b1;
        @(negedge clk);
        btn_start   = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_cnt(input logic [5:0] idx, input logic [3:0] exp);
        rd_idx = idx;
        #1;
        check($sformatf("count[%0d]", idx), 64'(rd_count), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        mine_map = '0;
        rd_idx = '0;
        {btn_start, btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = '0;
        repeat (2) @(negedge clk);
        check("rst_state", 64'(state), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cursor", 64'(cursor), 64'd0);
        check("rst_revealed", revealed, 64'd0);
        check("rst_mines", 64'(mines), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a load.
        @(negedge clk);
        mine_map  = '1;
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        check("load_busy", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        check("load_mines_partial", 64'(mines), 64'd10);
        rst_n = 1'b0;
        rd_idx = 6'd0;
        #1;
        check("midrst_mines", 64'(mines), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_count0", 64'(rd_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mine at cell 0.
        start_game(64'h1, cyc);
        check("busy_cycles", 64'(cyc), 64'd64);
        check("g1_state", 64'(state), 64'd1);
        check("g1_mines", 64'(mines), 64'd1);
        check_cnt(6'd1, 4'd1);
        check_cnt(6'd8, 4'd1);
        check_cnt(6'd9, 4'd1);
        check_cnt(6'd7, 4'd0);
        check_cnt(6'd63, 4'd0);
        check_cnt(6'd0, 4'd0);

        press(B_LEFT);
        check("clamp_left", 64'(cursor), 64'd0);
        press(B_UP);
        check("clamp_up", 64'(cursor), 64'd0);
        press_n(B_RIGHT, 7);
        check("right7", 64'(cursor), 64'd7);
        press(B_RIGHT);
        check("clamp_right", 64'(cursor), 64'd7);
        press_n(B_DOWN, 7);
        check("down7", 64'(cursor), 64'd63);
        press(B_UP | B_LEFT);
        check("up_over_left", 64'(cursor), 64'd55);

        press_n(B_UP, 5);
        press_n(B_LEFT, 6);
        check("cursor_to_9", 64'(cursor), 64'd9);
        press(B_FLAG);
        check("flag9", flagged, 64'h1 << 9);
        press(B_REVEAL);
        check("reveal_flagged", revealed, 64'd0);
        press(B_FLAG);
        check("unflag9", flagged, 64'd0);
        press(B_REVEAL);
        check("reveal9", revealed, 64'h1 << 9);
        press(B_REVEAL | B_FLAG);
        check("flag_dropped", flagged, 64'd0);
        press(B_FLAG);
        check("flag_on_revealed", flagged, 64'd0);
        check("g1_still_play", 64'(state), 64'd1);

        // Mine at cell 7: no wrap into the next row.
        start_game(64'h1 << 7, cyc);
        check_cnt(6'd8, 4'd0);
        check_cnt(6'd6, 4'd1);
        check_cnt(6'd15, 4'd1);
        check_cnt(6'd14, 4'd1);

        // Mine at cell 63: zero-count opening, then lose.
        start_game(64'h1 << 63, cyc);
        press(B_REVEAL);
        check("open_zero", revealed, 64'h303);
        check("open_state", 64'(state), 64'd1);
        press_n(B_RIGHT, 7);
        press_n(B_DOWN, 7);
        press(B_REVEAL);
        check("lose_state", 64'(state), 64'd2);
        check("lose_revealed", revealed, 64'h8000_0000_0000_0303);
        press(B_LEFT);
        check("lose_move_ignored", 64'(cursor), 64'd63);
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        check("restart_state", 64'(state), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_revealed", revealed, 64'd0);

        // Only cell 0 is safe: win one edge after the reveal.
        start_game(~64'h1, cyc);
        check("g4_mines", 64'(mines), 64'd63);
        press(B_REVEAL);
        check("win_pending", 64'(state), 64'd1);
        @(negedge clk);
        check("win_state", 64'(state), 64'd3);

        // No safe cells: win straight out of LOAD.
        start_game('1, cyc);
        check("allmine_cycles", 64'(cyc), 64'd64);
        check("allmine_state", 64'(state), 64'd3);
        check("allmine_mines", 64'(mines), 64'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
